// File: rtl/systolic_pkg.sv
// Shared types for the systolic operand feeder: default sizes, operand type and feeder FSM states.
package systolic_pkg;

    localparam int N_DEF  = 4;
    localparam int DW_DEF = 8;

    typedef logic [DW_DEF-1:0] operand_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } feed_state_t;

endpackage

// File: rtl/systolic_skew_feeder_skew_select.sv
// Diagonal skew lookup: for stream step s and lane index, the buffer slot feeding that lane
// (s - lane) and whether it lies inside the N-wide skew window.
module skew_select #(
    parameter int N   = 4,
    parameter int SW  = 3,
    parameter int SLW = 2
) (
    input  logic [SW-1:0]  s,
    input  logic [SW-1:0]  lane,
    output logic [SLW-1:0] slot,
    output logic           valid
);

    logic [SW-1:0] diff;

    assign diff  = s - lane;
    assign valid = (s >= lane) && (diff < SW'(N));
    assign slot  = diff[SLW-1:0];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for an N x N systolic MAC array: buffers one A/B operand set, then streams it
// to the array edges with diagonal skew, zero padding, a drain tail and a done pulse.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int DRAIN = N - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*DW-1:0] in_a_col,
    input  logic [N*DW-1:0] in_b_row,
    output logic [N*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output logic          acc_clr,
    output logic          busy,
    output logic          done
);

    localparam int SW  = $clog2(2 * N);
    localparam int CW  = $clog2(N + 1);
    localparam int DCW = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;
    localparam int SLW = (N > 1) ? $clog2(N) : 1;

    feed_state_t    state_q, state_d;
    logic [SW-1:0]  s_q, s_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;

    logic [N*DW-1:0] a_buf [N];
    logic [N*DW-1:0] b_buf [N];
    logic [N*DW-1:0] a_next, b_next;
    logic            accept, last_beat;

    assign in_ready  = (state_q == IDLE) || ((state_q == LOAD) && (cnt_q < CW'(N)));
    assign accept    = in_valid && in_ready;
    // cnt_q is 0 in IDLE, so this also covers the N == 1 case where the first beat is the last.
    assign last_beat = accept && (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = LOAD;
                    if (last_beat) begin
                        cnt_d   = '0;
                        s_d     = '0;
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (s_q == SW'(2 * N - 2)) begin
                    dcnt_d  = '0;
                    state_d = systolic_pkg::DRAIN;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            systolic_pkg::DRAIN: begin
                // One cycle beyond DRAIN so the output register flushes the last stream beat
                // before done rises.
                if (dcnt_q == DCW'(DRAIN)) begin
                    state_d = DONE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                s_d     = '0;
                dcnt_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand storage has no reset; its contents are meaningless until a full set is loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_buf[cnt_q[SLW-1:0]] <= in_a_col;
            b_buf[cnt_q[SLW-1:0]] <= in_b_row;
        end
    end

    // Lane i of A and lane j of B share the same skew (s - i), so one lookup serves both.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [SLW-1:0] slot;
        logic           vld;

        skew_select #(
            .N   (N),
            .SW  (SW),
            .SLW (SLW)
        ) u_skew (
            .s     (s_q),
            .lane  (SW'(i)),
            .slot  (slot),
            .valid (vld)
        );

        assign a_next[i*DW +: DW] = ((state_q == STREAM) && vld) ? a_buf[slot][i*DW +: DW] : '0;
        assign b_next[i*DW +: DW] = ((state_q == STREAM) && vld) ? b_buf[slot][i*DW +: DW] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            a_out   <= '0;
            b_out   <= '0;
            acc_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            a_out   <= a_next;
            b_out   <= b_next;
            acc_clr <= (state_q != STREAM) && (state_d == STREAM);
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: directed and random operand sets checked against
// a skew reference and a behavioural systolic array model.
module tb_systolic_skew_feeder;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DRAIN = 3;
    localparam int LAT   = 1 + (2 * N - 1) + DRAIN;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_a_col, in_b_row;
    logic [N*DW-1:0] a_out, b_out;
    logic            acc_clr, busy, done;

    int total = 0;
    int bad   = 0;

    // Set being fed, and the set currently expected on the outputs.
    int fa [N][N];
    int fb [N][N];
    int ca [N][N];
    int cb [N][N];

    // Behavioural array: A moves right, B moves down, each cell accumulates a*b.
    int pa  [N][N];
    int pb  [N][N];
    int acc [N][N];

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .N     (N),
        .DW    (DW),
        .DRAIN (DRAIN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a_col (in_a_col),
        .in_b_row (in_b_row),
        .a_out    (a_out),
        .b_out    (b_out),
        .acc_clr  (acc_clr),
        .busy     (busy),
        .done     (done)
    );

    function automatic int ain(int i, int j);
        if (j == 0) return int'(a_out[i*DW +: DW]);
        return pa[i][j-1];
    endfunction

    function automatic int bin(int i, int j);
        if (i == 0) return int'(b_out[j*DW +: DW]);
        return pb[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (acc_clr) begin
                    pa[i][j]  <= 0;
                    pb[i][j]  <= 0;
                    acc[i][j] <= 0;
                end else begin
                    pa[i][j]  <= ain(i, j);
                    pb[i][j]  <= bin(i, j);
                    acc[i][j] <= acc[i][j] + ain(i, j) * bin(i, j);
                end
            end
        end
    end

    function automatic logic [N*DW-1:0] exp_a(int s);
        logic [N*DW-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (s - i >= 0 && s - i < N) v[i*DW +: DW] = DW'(ca[i][s-i]);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(int s);
        logic [N*DW-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (s - j >= 0 && s - j < N) v[j*DW +: DW] = DW'(cb[s-j][j]);
        return v;
    endfunction

    function automatic int matmul(int i, int j);
        int sum = 0;
        for (int k = 0; k < N; k++) sum += ca[i][k] * cb[k][j];
        return sum;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < N; i++) begin
            in_a_col[i*DW +: DW] = DW'(fa[i][k]);
            in_b_row[i*DW +: DW] = DW'(fb[k][i]);
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                fa[i][k] = 16 * i + k;
                fb[i][k] = 16 * i + k + 128;
            end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                fa[i][k] = (i == k) ? 1 : 0;
                fb[i][k] = N * i + k + 1;
            end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                fa[i][k] = int'($urandom_range(255));
                fb[i][k] = int'($urandom_range(255));
            end
    endtask

    // Feed one set; returns right after the edge that accepted the last beat.
    task automatic feed(input int stall_after, input int stall_len, input bit hold);
        int waits;
        for (int k = 0; k < N; k++) begin
            drive_beat(k);
            in_valid = 1'b1;
            waits = 0;
            while (in_ready !== 1'b1 && waits < 40) begin
                tick();
                waits++;
            end
            if (waits >= 40) chk("ready_timeout", 64'(in_ready), 64'd1);
            tick();
            if (k < N - 1) begin
                chk($sformatf("acc_clr_early k=%0d", k), 64'(acc_clr), 64'd0);
                chk($sformatf("busy_load k=%0d", k), 64'(busy), 64'd1);
            end
            if (k == stall_after) begin
                in_valid = 1'b0;
                repeat (stall_len) begin
                    tick();
                    chk("stall_ready", 64'(in_ready), 64'd1);
                    chk("stall_busy", 64'(busy), 64'd1);
                    chk("stall_acc_clr", 64'(acc_clr), 64'd0);
                end
            end
        end
        ca = fa;
        cb = fb;
        in_valid = hold;
    endtask

    task automatic check_stream(input bit pattern);
        for (int m = 0; m <= LAT + 1; m++) begin
            chk($sformatf("acc_clr m=%0d", m), 64'(acc_clr), (m == 0) ? 64'd1 : 64'd0);
            if (m >= 1 && m <= 2 * N - 1) begin
                chk($sformatf("a_out m=%0d", m), 64'(a_out), 64'(exp_a(m - 1)));
                chk($sformatf("b_out m=%0d", m), 64'(b_out), 64'(exp_b(m - 1)));
            end else begin
                chk($sformatf("a_zero m=%0d", m), 64'(a_out), 64'd0);
                chk($sformatf("b_zero m=%0d", m), 64'(b_out), 64'd0);
            end
            if (pattern && m == 1) begin
                chk("pat_a_s0", 64'(a_out), 64'h0000_0000);
                chk("pat_b_s0", 64'(b_out), 64'h0000_0080);
            end
            if (pattern && m == 4) begin
                chk("pat_a_s3", 64'(a_out), 64'h3021_1203);
                chk("pat_b_s3", 64'(b_out), 64'h8392_A1B0);
            end
            if (pattern && m == 7) begin
                chk("pat_a_s6", 64'(a_out), 64'h3300_0000);
                chk("pat_b_s6", 64'(b_out), 64'hB300_0000);
            end
            chk($sformatf("done m=%0d", m), 64'(done), (m == LAT) ? 64'd1 : 64'd0);
            chk($sformatf("busy m=%0d", m), 64'(busy), (m <= LAT) ? 64'd1 : 64'd0);
            chk($sformatf("in_ready m=%0d", m), 64'(in_ready), (m == LAT + 1) ? 64'd1 : 64'd0);
            if (m == LAT) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        chk($sformatf("c[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(matmul(i, j)));
            end
            if (m <= LAT) tick();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a_col = '0;
        in_b_row = '0;
        #12;
        chk("rst_a_out", 64'(a_out), 64'd0);
        chk("rst_b_out", 64'(b_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_acc_clr", 64'(acc_clr), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Skew pattern with a 5-cycle valid gap between beats 1 and 2.
        fill_pattern();
        feed(1, 5, 1'b0);
        check_stream(1'b1);

        // Identity A: the array result must equal B.
        fill_identity();
        feed(-1, 0, 1'b0);
        check_stream(1'b0);

        // Back-to-back random sets with in_valid held high throughout.
        fill_random();
        for (int r = 0; r < 3; r++) begin
            feed(-1, 0, (r < 2));
            if (r < 2) begin
                fill_random();
                drive_beat(0);
            end
            check_stream(1'b0);
        end

        // Random set with a random stall position.
        fill_random();
        feed(int'($urandom_range(N - 2)), int'($urandom_range(1, 4)), 1'b0);
        check_stream(1'b0);

        // Reset in the middle of the stream, at s = 3.
        fill_pattern();
        feed(-1, 0, 1'b0);
        for (int m = 0; m < 4; m++) tick();
        chk("mid_a_s3", 64'(a_out), 64'h3021_1203);
        chk("mid_b_s3", 64'(b_out), 64'h8392_A1B0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_a_out", 64'(a_out), 64'd0);
        chk("async_b_out", 64'(b_out), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_done", 64'(done), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Recovery after reset.
        fill_random();
        feed(-1, 0, 1'b0);
        check_stream(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream operand feeder for the N×N systolic MAC array.
- Accepts matrix A column-by-column and matrix B row-by-row over a valid/ready load port, then buffers one full N-beat operand set.
- Drives the array's left-edge A inputs and top-edge B inputs with diagonal skew (row/column i delayed i cycles), zero-padding every slot outside the skew window.
- Signals completion once the last product has reached cell (N-1,N-1).

Parameters:
- N, 4, array dimension: rows = columns = beats per load.
- DW, 8, operand width in bits.
- DRAIN, N-1, zero-padding cycles after the stream before done.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  load beat valid.
- in_ready  out  1  feeder can accept a load beat.
- in_a_col  in  N*DW  beat k: A[i][k] for lane i, packed at bits [i*DW +: DW].
- in_b_row  in  N*DW  beat k: B[k][j] for lane j, packed at bits [j*DW +: DW].
- a_out  out  N*DW  per-row A operand to the array's left edge, lane i → row i.
- b_out  out  N*DW  per-column B operand to the array's top edge, lane j → column j.
- acc_clr  out  1  one-cycle pulse preceding the first stream cycle.
- busy  out  1  high in LOAD, STREAM, DRAIN and DONE.
- done  out  1  one-cycle pulse; array result is now stable.

Behaviour:
- Reset is asynchronous and active-low on rst_n; the single clock is clk.
- Reset values: state IDLE, all counters 0, a_out/b_out 0, acc_clr 0, done 0, busy 0.
- Reset may occur mid-operation. It aborts any load or stream, and outputs return to 0 immediately (asynchronous). Buffer contents are don't-care after reset.
- All outputs are flops. in_ready is combinational from state and beat counter only, never from in_valid.
- A beat is accepted when in_valid && in_ready on a rising edge.
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - An accepted beat is written to buffer slot 0 with beat count 1, and the FSM moves to LOAD.
- LOAD:
  - in_ready=1 while count < N.
  - Beat k is written to slot k.
  - On acceptance of beat N-1, go to STREAM next cycle with s=0. acc_clr pulses high in that same transition cycle, i.e. the cycle in which the last beat is accepted. No bubble between load completion and stream.
  - in_valid low stalls LOAD indefinitely with no timeout.
- STREAM, s = 0..2N-2, in_ready=0:
  - a_out lane i = A[i][s-i] (from slot s-i) when 0 <= s-i < N, else 0.
  - b_out lane j = B[s-j][j] (from slot s-j) when 0 <= s-j < N, else 0.
  - At s=2N-2 go to DRAIN.
- DRAIN:
  - a_out=b_out=0 for DRAIN cycles (count 0..DRAIN-1), then DONE.
  - DRAIN=0 goes straight to DONE.
- DONE:
  - done=1 for exactly one cycle, outputs 0, in_ready=0; next state IDLE.
  - A beat presented in DONE is not accepted. It is accepted in the following IDLE cycle.
- Latency: from last load beat accepted to done = 1 + (2N-1) + DRAIN cycles, i.e. 11 cycles at N=4.
- No arithmetic on operands; values pass bit-exact.
- Counter widths: $clog2(2N) for s and $clog2(N+1) for the beat counter. Wrap-around cannot occur because the FSM exits before terminal count + 1.
- busy = (state != IDLE).
- Back-to-back operand sets are allowed: IDLE → LOAD with no extra gap beyond the DONE cycle.

Decomposition:
- Shared package systolic_pkg holds:
  - localparams N_DEF=4 and DW_DEF=8;
  - typedef operand_t (logic [DW-1:0]);
  - typedef enum feed_state_t {IDLE, LOAD, STREAM, DRAIN, DONE}.
- One natural sub-module: skew_select. Combinational; given s and lane index it returns the slot index and a valid flag, instantiated per lane for A and B.
- Buffer storage stays in the top level.

Test Plan:
- Reset check: assert rst_n=0 mid-STREAM (s=3) → a_out, b_out, busy, done read 0 within the same cycle. After release, in_ready=1 and state is IDLE.
- Skew order: load A[i][k]=16*i+k, B[k][j]=16*k+j+128. During STREAM:
  - s=0: a_out={0,0,0,0x00}, b_out={0,0,0,0x80};
  - s=3: a_out lanes 0..3 = {0x03,0x12,0x21,0x30}, b_out lanes 0..3 = {0xB0,0xA1,0x92,0x83};
  - s=6: only lane 3 nonzero (a=0x33, b=0xB3).
- Handshake stall: deassert in_valid between beats 1 and 2 for 5 cycles → FSM stays in LOAD with in_ready=1. The stream then starts exactly 1 cycle after beat 3 is accepted, and acc_clr pulses once.
- Timing: last beat accepted at edge T → done high only in cycle T+11, busy low at T+12.
- Back-to-back: hold in_valid=1 continuously with two operand sets → second set is accepted starting in the IDLE cycle after DONE, and no beat is accepted while in_ready=0.
- End-to-end: feed A=identity, B=[[1..4],[5..8],[9..12],[13..16]] into the array → at done, C equals B.
